// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator: mode encodings,
// colour-bar lookup and the 640x480@60 default timing set.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  // {r,g,b} on/off flags per bar, index 0 (leftmost) in the LSBs:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_LUT = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

endpackage

// File: rtl/vga_timing_core.sv
// Pixel-rate divider, horizontal/vertical counters, sync/active decode
// of the current counts, and the registered frame_start pulse.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP
) (
  input  logic           clk,
  input  logic           rst,
  output logic           pix_ce,
  output logic [X_W-1:0] hcnt,
  output logic [Y_W-1:0] vcnt,
  output logic           hs_act,
  output logic           vs_act,
  output logic           de_act,
  output logic           at_origin,
  output logic           frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (PIX_DIV == 1) begin : g_no_div
      assign pix_ce = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(PIX_DIV);
      localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
      logic [DW-1:0] div;

      // NOTE: sequential state uses non-blocking assignments so every
      // flop samples pre-edge values regardless of block ordering.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                  div <= '0;
        else if (div == DIV_LAST) div <= '0;
        else                      div <= div + 1'b1;
      end

      assign pix_ce = (div == DIV_LAST);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_ce) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  assign hs_act    = (hcnt >= HS_START) && (hcnt < HS_END);
  assign vs_act    = (vcnt >= VS_START) && (vcnt < VS_END);
  assign de_act    = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign at_origin = (hcnt == '0) && (vcnt == '0);

  // Registered so it lands on the same edge as the pixel (0,0) outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_start <= 1'b0;
    else     frame_start <= pix_ce && at_origin;
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing front end with test-pattern engine and frame-synchronous
// mode switching. Define VGA_PATTERN_BORDER_EN to add a white border.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int   COLOR_W  = 4,
  parameter int   PIX_DIV  = 4,
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FP     = VGA640_H_FP,
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BP     = VGA640_H_BP,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FP     = VGA640_V_FP,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BP     = VGA640_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_req,
  input  logic [1:0]           mode_sel,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic                 mode_pend,
  output logic [1:0]           mode_cur,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [X_W-1:0]       x,
  output logic [Y_W-1:0]       y,
  output logic                 frame_start
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic           pix_ce;
  logic [X_W-1:0] hcnt;
  logic [Y_W-1:0] vcnt;
  logic           hs_act, vs_act, de_act, at_origin;

  vga_timing_core #(
    .PIX_DIV (PIX_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .hcnt       (hcnt),
    .vcnt       (vcnt),
    .hs_act     (hs_act),
    .vs_act     (vs_act),
    .de_act     (de_act),
    .at_origin  (at_origin),
    .frame_start(frame_start)
  );

  logic [1:0] shadow;
  mode_e      cur_q;
  mode_e      frame_mode;
  logic       boundary;

  assign boundary = pix_ce && at_origin;
  assign mode_cur = cur_q;

  // A request on the boundary edge itself is latched for the next frame;
  // the copy uses the shadow value from before that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= 2'd0;
      cur_q     <= MODE_BARS;
      mode_pend <= 1'b0;
    end else begin
      if (boundary && mode_pend) begin
        cur_q     <= mode_e'(shadow);
        mode_pend <= 1'b0;
      end
      if (mode_req) begin
        shadow    <= mode_sel;
        mode_pend <= 1'b1;
      end
    end
  end

  // Pixel (0,0) is rendered on the copy edge, so it already uses the new mode.
  assign frame_mode = (at_origin && mode_pend) ? mode_e'(shadow) : cur_q;

  logic [2:0]         bar_idx;
  logic [COLOR_W-1:0] pr, pg, pb;

  // NOTE: every always_comb output gets a default first, so no path
  // through the block can leave a value held and infer a latch.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hcnt >= X_W'(k * BAR_W)) bar_idx = 3'(k);
    end

    pr = '0;
    pg = '0;
    pb = '0;
    case (frame_mode)
      MODE_SOLID: begin
        pr = solid_rgb[3*COLOR_W-1:2*COLOR_W];
        pg = solid_rgb[2*COLOR_W-1:COLOR_W];
        pb = solid_rgb[COLOR_W-1:0];
      end
      MODE_BARS: begin
        pr = {COLOR_W{BAR_LUT[bar_idx][2]}};
        pg = {COLOR_W{BAR_LUT[bar_idx][1]}};
        pb = {COLOR_W{BAR_LUT[bar_idx][0]}};
      end
      MODE_CHECK: begin
        pr = {COLOR_W{hcnt[3] ^ vcnt[3]}};
        pg = {COLOR_W{hcnt[3] ^ vcnt[3]}};
        pb = {COLOR_W{hcnt[3] ^ vcnt[3]}};
      end
      MODE_GRAD: begin
        pr = hcnt[COLOR_W+3:4];
        pg = vcnt[COLOR_W+3:4];
        pb = ~hcnt[COLOR_W+3:4];
      end
      default: ;
    endcase

`ifdef VGA_PATTERN_BORDER_EN
    if (hcnt == '0 || hcnt == X_W'(H_ACTIVE - 1) ||
        vcnt == '0 || vcnt == Y_W'(V_ACTIVE - 1)) begin
      pr = '1;
      pg = '1;
      pb = '1;
    end
`endif

    if (!de_act) begin
      pr = '0;
      pg = '0;
      pb = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r     <= '0;
      g     <= '0;
      b     <= '0;
      de    <= 1'b0;
      x     <= '0;
      y     <= '0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
    end else if (pix_ce) begin
      r     <= pr;
      g     <= pg;
      b     <= pb;
      de    <= de_act;
      x     <= hcnt;
      y     <= vcnt;
      hsync <= hs_act ? HS_POL : ~HS_POL;
      vsync <= vs_act ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: timing, patterns, mode handshake,
// reset, plus a PIX_DIV=1 tiny-raster instance.
module tb_vga_pattern_gen;

  localparam int LINE_CLK  = 88;    // 44 pixels * 2 clk
  localparam int FRAME_CLK = 2288;  // 26 lines * 88 clk
  localparam int WAIT_MAX  = FRAME_CLK + 2 * LINE_CLK;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode_req = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic [11:0] solid_rgb = 12'h123;
  logic        mode_pend, hsync, vsync, de, frame_start;
  logic [1:0]  mode_cur;
  logic [3:0]  r, g, b;
  logic [10:0] x;
  logic [9:0]  y;

  logic        mode_pend2, hsync2, vsync2, de2, frame_start2;
  logic [1:0]  mode_cur2;
  logic [3:0]  r2, g2, b2;
  logic [10:0] x2;
  logic [9:0]  y2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .COLOR_W(4), .PIX_DIV(2),
    .H_ACTIVE(36), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .mode_req(mode_req), .mode_sel(mode_sel),
    .solid_rgb(solid_rgb), .mode_pend(mode_pend), .mode_cur(mode_cur),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y), .frame_start(frame_start)
  );

  vga_pattern_gen #(
    .COLOR_W(4), .PIX_DIV(1),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst), .mode_req(1'b0), .mode_sel(2'd0),
    .solid_rgb(12'h000), .mode_pend(mode_pend2), .mode_cur(mode_cur2),
    .r(r2), .g(g2), .b(b2), .hsync(hsync2), .vsync(vsync2), .de(de2),
    .x(x2), .y(y2), .frame_start(frame_start2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < WAIT_MAX; n++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_pixel(input int px, input int py, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < WAIT_MAX; n++) begin
      @(negedge clk);
      if (x == 11'(px) && y == 10'(py)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic set_mode(input int m);
    bit ok;
    @(negedge clk);
    mode_req = 1'b1;
    mode_sel = 2'(m);
    @(negedge clk);
    mode_req = 1'b0;
    check("set_pend", 32'(mode_pend), 1);
    wait_fs(ok);
    check("set_fs_timeout", 32'(ok), 1);
    check("set_mode_cur", 32'(mode_cur), 32'(m));
    check("set_pend_clr", 32'(mode_pend), 0);
  endtask

  typedef struct {
    int mode; int px; int py; int de; int r; int g; int b;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(int m, int px, int py, int e_de, int er, int eg, int eb);
    vec_t v;
    v.mode = m; v.px = px; v.py = py; v.de = e_de; v.r = er; v.g = eg; v.b = eb;
    vecs.push_back(v);
  endfunction

  initial begin
    bit ok;
    int n, bad, lo, hi, cur;

    // bars: width 36/8=4, columns 32..35 repeat black
    add_vec(1,  3, 5, 1, 15, 15, 15);
    add_vec(1,  4, 5, 1, 15, 15,  0);
    add_vec(1,  8, 5, 1,  0, 15, 15);
    add_vec(1, 12, 5, 1,  0, 15,  0);
    add_vec(1, 16, 5, 1, 15,  0, 15);
    add_vec(1, 20, 5, 1, 15,  0,  0);
    add_vec(1, 24, 5, 1,  0,  0, 15);
    add_vec(1, 28, 5, 1,  0,  0,  0);
    add_vec(1, 33, 5, 1,  0,  0,  0);
    add_vec(1, 36, 5, 0,  0,  0,  0);
    add_vec(2,  0, 0, 1,  0,  0,  0);
    add_vec(2,  8, 0, 1, 15, 15, 15);
    add_vec(2, 15, 7, 1, 15, 15, 15);
    add_vec(2,  0, 8, 1, 15, 15, 15);
    add_vec(2,  8, 8, 1,  0,  0,  0);
    add_vec(3,  5, 3, 1,  0,  0, 15);
    add_vec(3, 20, 17, 1, 1,  1, 14);
    add_vec(3, 35, 19, 1, 2,  1, 13);
    add_vec(0, 10, 10, 1, 1,  2,  3);
    add_vec(0, 36, 10, 0, 0,  0,  0);

    // Reset state while rst is held
    #23;
    check("rst_hsync", 32'(hsync), 1);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_de", 32'(de), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_mode_cur", 32'(mode_cur), 1);
    check("rst_pend", 32'(mode_pend), 0);
    check("rst_rgb", {20'd0, r, g, b}, 0);

    // First pix_ce after release gives pixel (0,0) with frame_start
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 64);
    check("first_fs_latency", n, 2);
    check("first_x", 32'(x), 0);
    check("first_y", 32'(y), 0);
    check("first_de", 32'(de), 1);
    @(negedge clk);
    check("fs_width", 32'(frame_start), 0);

    n = 1;
    while (!frame_start && n < 2 * FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    check("frame_period", n, FRAME_CLK);

    // hsync: falls at column 38, 4 pixels low, line period 88 clk
    ok = 1'b0;
    for (int i = 0; i < WAIT_MAX && !ok; i++) begin
      @(negedge clk);
      if (!hsync) ok = 1'b1;
    end
    check("hs_found", 32'(ok), 1);
    check("hs_start_col", 32'(x), 38);
    lo = 0;
    while (!hsync && lo < LINE_CLK) begin @(negedge clk); lo++; end
    hi = 0;
    while (hsync && hi < 2 * LINE_CLK) begin @(negedge clk); hi++; end
    check("hs_low_clk", lo, 8);
    check("hs_period_clk", lo + hi, LINE_CLK);

    // vsync: falls at pixel (0,22), 2 lines low
    ok = 1'b0;
    for (int i = 0; i < WAIT_MAX && !ok; i++) begin
      @(negedge clk);
      if (!vsync) ok = 1'b1;
    end
    check("vs_found", 32'(ok), 1);
    check("vs_start_line", 32'(y), 22);
    check("vs_start_col", 32'(x), 0);
    lo = 0;
    while (!vsync && lo < FRAME_CLK) begin @(negedge clk); lo++; end
    check("vs_low_clk", lo, 2 * LINE_CLK);

    // Request mode 2 mid-frame: pending until the next frame boundary
    cur = int'(mode_cur);
    wait_pixel(0, 10, ok);
    check("hs_wait_timeout", 32'(ok), 1);
    mode_req = 1'b1;
    mode_sel = 2'd2;
    @(negedge clk);
    mode_req = 1'b0;
    check("req_pend", 32'(mode_pend), 1);
    check("req_cur_kept", 32'(mode_cur), 32'(cur));
    bad = 0;
    ok = 1'b0;
    for (int i = 0; i < WAIT_MAX && !ok; i++) begin
      @(negedge clk);
      if (frame_start) ok = 1'b1;
      else if (!mode_pend) bad++;
    end
    check("req_fs_timeout", 32'(ok), 1);
    check("req_pend_held", bad, 0);
    check("req_pend_clr", 32'(mode_pend), 0);
    check("req_cur_new", 32'(mode_cur), 2);
    check("req_px00_black", {20'd0, r, g, b}, 0);
    wait_pixel(8, 0, ok);
    check("req_px80_white", {20'd0, r, g, b}, 12'hFFF);

    // Pattern table
    cur = -1;
    foreach (vecs[i]) begin
      if (vecs[i].mode != cur) begin
        set_mode(vecs[i].mode);
        cur = vecs[i].mode;
      end
      wait_pixel(vecs[i].px, vecs[i].py, ok);
      check($sformatf("vec%0d_timeout", i), 32'(ok), 1);
      check($sformatf("vec%0d_de", i), 32'(de), 32'(vecs[i].de));
      check($sformatf("vec%0d_rgb", i), {20'd0, r, g, b},
            32'((vecs[i].r << 8) | (vecs[i].g << 4) | vecs[i].b));
    end

    // Request on the boundary edge: copy uses old shadow (3), new (2) stays pending
    wait_fs(ok);
    mode_req = 1'b1;
    mode_sel = 2'd3;
    @(negedge clk);
    mode_req = 1'b0;
    repeat (FRAME_CLK - 2) @(negedge clk);
    mode_req = 1'b1;
    mode_sel = 2'd2;
    @(negedge clk);
    mode_req = 1'b0;
    check("coinc_fs", 32'(frame_start), 1);
    check("coinc_cur", 32'(mode_cur), 3);
    check("coinc_pend", 32'(mode_pend), 1);
    wait_fs(ok);
    check("coinc_next_cur", 32'(mode_cur), 2);
    check("coinc_next_pend", 32'(mode_pend), 0);

    // Back-to-back requests 3 then 0: last one wins
    wait_pixel(0, 5, ok);
    mode_req = 1'b1;
    mode_sel = 2'd3;
    @(negedge clk);
    mode_sel = 2'd0;
    @(negedge clk);
    mode_req = 1'b0;
    wait_fs(ok);
    check("b2b_cur", 32'(mode_cur), 0);
    wait_pixel(10, 10, ok);
    check("b2b_rgb", {20'd0, r, g, b}, 12'h123);

    // Asynchronous reset mid-line, checked before any clk edge
    wait_pixel(10, 5, ok);
    #2;
    rst = 1'b1;
    #1;
    check("arst_x", 32'(x), 0);
    check("arst_y", 32'(y), 0);
    check("arst_de", 32'(de), 0);
    check("arst_hsync", 32'(hsync), 1);
    check("arst_rgb", {20'd0, r, g, b}, 0);
    check("arst_mode_cur", 32'(mode_cur), 1);
    check("arst_pend", 32'(mode_pend), 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 64);
    check("arst_fs_latency", n, 2);
    check("arst_fs_xy", {11'd0, x, y}, 0);

    // PIX_DIV=1 instance: 22 clk lines, 242 clk frames, de 16/22, hsync high 2/22
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (frame_start2) ok = 1'b1;
    end
    check("d2_fs_found", 32'(ok), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start2 && n < 600);
    check("d2_frame_period", n, 242);
    lo = 0;
    hi = 0;
    repeat (22) begin
      @(negedge clk);
      if (de2) lo++;
      if (hsync2) hi++;
    end
    check("d2_de_per_line", lo, 16);
    check("d2_hsync_per_line", hi, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
